player_shot_ctrl: RTL and testbench
===================================

PLAYER_SHOT_CTRL -- requirements
Module: player_shot_ctrl

Interface
REQ-001 SHALL have parameter N_SHOTS, default 8, number of shot slots.
REQ-002 SHALL have parameter MOVE_DIV, default 400000, clk_in cycles per movement tick.
REQ-003 SHALL have parameter COOLDOWN, default 6, ticks between spawns.
REQ-004 SHALL have parameter SPEED, default 4, pixels moved upward per tick.
REQ-005 SHALL have parameters BOSS_HW, default 32, and BOSS_HH, default 48, the boss hitbox half-width and half-height in pixels.
REQ-006 SHALL have parameter SHOT_RGB, default 12'hF0F, shot pixel colour.
REQ-007 SHALL have port clk_in, input, 1, system clock.
REQ-008 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-009 SHALL have port fire, input, 1, level fire request.
REQ-010 SHALL have ports player_x and player_y, input, 10 each, player centre position.
REQ-011 SHALL have ports boss_x and boss_y, input, 10 each, boss centre position.
REQ-012 SHALL have port boss_die, input, 1, boss dead flag.
REQ-013 SHALL have ports x and y, input, 10 each, current scan pixel.
REQ-014 SHALL have port is_hit, output, 1, registered one-cycle hit pulse to the boss block.
REQ-015 SHALL have port shot_on, output, 1, high when the current pixel is covered by a shot.
REQ-016 SHALL have port rgb_out, output, 12, pixel colour.
REQ-017 SHALL have port shots_active, output, 4, registered count of active slots.

Function
REQ-018 SHALL run a tick counter 0..MOVE_DIV-1; tick asserts for one cycle when the count equals MOVE_DIV-1, then the count wraps to 0.
REQ-019 SHALL keep, per slot, an active bit plus 10-bit sx and sy, all changing only on tick cycles.
REQ-020 SHALL, on tick, resolve each active slot in this order: collision, then boundary check, then movement.
REQ-021 SHALL detect collision when slot active, boss_die=0, |sx-boss_x| <= BOSS_HW and |sy-boss_y| <= BOSS_HH, with differences computed 11-bit signed; on collision the slot clears and does not move.
REQ-022 SHALL clear a non-colliding slot with sy < SPEED (off-screen, no underflow); otherwise it SHALL update sy to sy-SPEED.
REQ-023 SHALL spawn on tick when fire=1, cooldown=0, player_y >= 16, and a free slot exists (as of the start of the tick).
REQ-024 SHALL spawn into the lowest-index free slot with sx=player_x, sy=player_y-16, and reload cooldown to COOLDOWN.
REQ-025 SHALL NOT spawn and SHALL NOT reload cooldown when all slots are full or player_y < 16.
REQ-026 SHALL exclude a newly spawned shot from collision and movement until the next tick.
REQ-027 SHALL decrement cooldown by 1 on each tick while it is nonzero, but not on the tick that reloads it.
REQ-028 SHALL add the number of hits in a tick to a 4-bit hit_pending counter, saturating at 15.
REQ-029 SHALL drive is_hit high for one cycle and decrement hit_pending when hit_pending>0 and is_hit was low last cycle, so consecutive pulses are separated by at least one low cycle.
REQ-030 SHALL give priority to the tick's add over the decrement when both fall on the same cycle (net = pending + hits - 1, saturated).
REQ-031 SHALL disable collision while boss_die=1; shots still move and retire normally.
REQ-032 SHALL assert shot_on combinationally when any active slot satisfies sx-1 <= x <= sx+2 and sy-5 <= y <= sy+6, computed 11-bit so no wrap occurs near 0.
REQ-033 SHALL drive rgb_out = SHOT_RGB when shot_on=1, else 12'h000.
REQ-034 SHALL update shots_active one cycle after any slot change.

Reset
REQ-035 SHALL, on reset, immediately clear all slots, the tick counter, cooldown, hit_pending, is_hit and shots_active, regardless of pending hits.
REQ-036 SHALL resume counting from 0 after reset deasserts; the first tick occurs MOVE_DIV cycles later.

Verification
REQ-037 SHALL cover single shot (MOVE_DIV=4, fire=1 one tick, player=(192,400), boss_die=1) -> one slot at (192,384); sy drops 4 per tick; slot clears on the tick when sy<4; shots_active returns to 0.
REQ-038 SHALL cover hit (boss=(192,100), shot spawned at sy=152) -> is_hit pulses once on the tick where sy=148; the slot clears; no further is_hit.
REQ-039 SHALL cover pool full (fire held, COOLDOWN=0, boss_die=1) -> shots_active saturates at 8 with no spawn while full; spawning resumes on the tick after a slot retires.
REQ-040 SHALL cover multi-hit (3 shots colliding on one tick) -> three is_hit pulses on cycles t+1, t+3, t+5.
REQ-041 SHALL cover reset mid-flight (4 shots active, hit_pending=2, reset) -> all outputs 0 immediately; no is_hit after release.
REQ-042 SHALL cover edge render (shot at (1,5), scan pixel x=0, y=0) -> shot_on=1; scan pixel x=1023 -> shot_on=0.

Source files
------------

// File: rtl/player_shot_ctrl_if.sv
// Bundle of game-state inputs, scan position and shot outputs for player_shot_ctrl.
// The master side (game logic / bench) drives fire, positions and scan pixel.
// The slave side (shot controller) returns the hit pulse, pixel colour and slot count.
interface player_shot_ctrl_if;
  logic       fire;
  logic [9:0] player_x;
  logic [9:0] player_y;
  logic [9:0] boss_x;
  logic [9:0] boss_y;
  logic       boss_die;
  logic [9:0] x;
  logic [9:0] y;
  logic       is_hit;
  logic       shot_on;
  logic [11:0] rgb_out;
  logic [3:0] shots_active;

  modport master (
    output fire, player_x, player_y, boss_x, boss_y, boss_die, x, y,
    input  is_hit, shot_on, rgb_out, shots_active
  );

  modport slave (
    input  fire, player_x, player_y, boss_x, boss_y, boss_die, x, y,
    output is_hit, shot_on, rgb_out, shots_active
  );
endinterface

// File: rtl/player_shot_ctrl.sv
// Player shot pool: spawns, moves, retires and collides shots against the boss; renders shot pixels.
// Latency: slot state changes on movement ticks; is_hit/shots_active registered (1 cycle); shot_on/rgb_out combinational.
// Backpressure: none; fire is a level request honoured on ticks when cooldown is 0 and a slot is free.
module player_shot_ctrl #(
  parameter int          N_SHOTS  = 8,
  parameter int          MOVE_DIV = 400000,
  parameter int          COOLDOWN = 6,
  parameter int          SPEED    = 4,
  parameter int          BOSS_HW  = 32,
  parameter int          BOSS_HH  = 48,
  parameter logic [11:0] SHOT_RGB = 12'hF0F
) (
  input logic               clk_in,
  input logic               reset,
  player_shot_ctrl_if.slave sc
);

  localparam int CNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam int IDX_W = (N_SHOTS > 1) ? $clog2(N_SHOTS) : 1;
  localparam int HIT_W = $clog2(N_SHOTS + 1);
  // wide enough for a saturated pending count (15) plus every slot hitting at once
  localparam int AV_W  = $clog2(16 + N_SHOTS);

  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic [N_SHOTS-1:0] act;
  logic [9:0]       sx [N_SHOTS];
  logic [9:0]       sy [N_SHOTS];
  logic [N_SHOTS-1:0] hit_vec;
  logic [N_SHOTS-1:0] pix_vec;
  logic [CD_W-1:0]  cooldown;
  logic             any_free;
  logic [IDX_W-1:0] spawn_idx;
  logic             spawn_ok;
  logic [HIT_W-1:0] hit_cnt;
  logic [3:0]       hit_pending;
  logic             is_hit_q;
  logic [AV_W-1:0]  avail;
  logic [AV_W-1:0]  remain;
  logic             hit_dec;
  logic [3:0]       pend_nxt;
  logic [3:0]       act_cnt;
  logic [3:0]       shots_active_q;

  assign tick = (tick_cnt == CNT_W'(MOVE_DIV - 1));

  // free-running movement divider, one tick per MOVE_DIV cycles
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset)     tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + CNT_W'(1);
  end

  // per-slot collision and pixel-coverage tests, all done 11-bit so nothing wraps near 0
  for (genvar g = 0; g < N_SHOTS; g++) begin : g_slot
    logic [10:0] dx;
    logic [10:0] dy;
    logic [10:0] adx;
    logic [10:0] ady;
    logic [10:0] px;
    logic [10:0] py;
    logic [10:0] ssx;
    logic [10:0] ssy;

    assign ssx = {1'b0, sx[g]};
    assign ssy = {1'b0, sy[g]};
    assign dx  = ssx - {1'b0, sc.boss_x};
    assign dy  = ssy - {1'b0, sc.boss_y};
    assign adx = dx[10] ? (11'd0 - dx) : dx;
    assign ady = dy[10] ? (11'd0 - dy) : dy;
    assign hit_vec[g] = act[g] & ~sc.boss_die &
                        (adx <= 11'(BOSS_HW)) & (ady <= 11'(BOSS_HH));

    // sx-1 <= x <= sx+2 and sy-5 <= y <= sy+6, rearranged to avoid subtracting from sx/sy
    assign px = {1'b0, sc.x};
    assign py = {1'b0, sc.y};
    assign pix_vec[g] = act[g] &
                        (px + 11'd1 >= ssx) & (px <= ssx + 11'd2) &
                        (py + 11'd5 >= ssy) & (py <= ssy + 11'd6);
  end

  // lowest-index free slot as of the start of the tick
  always_comb begin
    any_free  = 1'b0;
    spawn_idx = '0;
    for (int i = N_SHOTS - 1; i >= 0; i--) begin
      if (!act[i]) begin
        any_free  = 1'b1;
        spawn_idx = IDX_W'(i);
      end
    end
  end

  assign spawn_ok = tick & sc.fire & (cooldown == '0) &
                    (sc.player_y >= 10'd16) & any_free;

  // slot state: collision beats retirement beats movement; the spawned slot is left alone until the next tick
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      act <= '0;
      for (int i = 0; i < N_SHOTS; i++) begin
        sx[i] <= '0;
        sy[i] <= '0;
      end
    end else if (tick) begin
      for (int i = 0; i < N_SHOTS; i++) begin
        if (hit_vec[i])             act[i] <= 1'b0;
        else if (act[i]) begin
          if (sy[i] < 10'(SPEED))   act[i] <= 1'b0;
          else                      sy[i]  <= sy[i] - 10'(SPEED);
        end
      end
      if (spawn_ok) begin
        act[spawn_idx] <= 1'b1;
        sx[spawn_idx]  <= sc.player_x;
        sy[spawn_idx]  <= sc.player_y - 10'd16;
      end
    end
  end

  // cooldown reloads on a spawn and otherwise counts down once per tick
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset)                         cooldown <= '0;
    else if (spawn_ok)                 cooldown <= CD_W'(COOLDOWN);
    else if (tick && cooldown != '0)   cooldown <= cooldown - CD_W'(1);
  end

  // number of slots colliding on this tick
  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < N_SHOTS; i++) begin
      hit_cnt = hit_cnt + HIT_W'(hit_vec[i] & tick);
    end
  end

  // new hits join the queue before the pulse decision, so a hit can pulse on the very next cycle
  always_comb begin
    avail    = AV_W'(hit_pending) + AV_W'(hit_cnt);
    hit_dec  = (avail != '0) & ~is_hit_q;
    remain   = avail - AV_W'(hit_dec);
    pend_nxt = (remain > AV_W'(15)) ? 4'd15 : remain[3:0];
  end

  // hit pulse generator, never two high cycles back to back
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      hit_pending <= '0;
      is_hit_q    <= 1'b0;
    end else begin
      hit_pending <= pend_nxt;
      is_hit_q    <= hit_dec;
    end
  end

  // live slot count; assumes N_SHOTS <= 15 so it fits the 4-bit output
  always_comb begin
    act_cnt = '0;
    for (int i = 0; i < N_SHOTS; i++) begin
      act_cnt = act_cnt + 4'(act[i]);
    end
  end

  // registered copy of the slot count, one cycle behind the slots
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) shots_active_q <= '0;
    else       shots_active_q <= act_cnt;
  end

  assign sc.is_hit       = is_hit_q;
  assign sc.shots_active = shots_active_q;
  assign sc.shot_on      = |pix_vec;
  assign sc.rgb_out      = sc.shot_on ? SHOT_RGB : 12'h000;

endmodule

// File: tb/tb_player_shot_ctrl.sv
// Bench for player_shot_ctrl: two instances (cooldown 3 and 0) share one stimulus stream
// and are compared every cycle against a cycle-level reference model of the shot pool,
// with directed scenarios followed by a randomized phase.
module tb_player_shot_ctrl;
  localparam int          N_SHOTS  = 8;
  localparam int          MOVE_DIV = 4;
  localparam int          SPEED    = 4;
  localparam int          BOSS_HW  = 32;
  localparam int          BOSS_HH  = 48;
  localparam logic [11:0] SHOT_RGB = 12'hF0F;
  localparam int          COOL_A   = 3;
  localparam int          COOL_B   = 0;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       fire, bdie;
  logic [9:0] px, py, bx, by, x, y;

  always #5 clk_in = ~clk_in;

  player_shot_ctrl_if if_a ();
  player_shot_ctrl_if if_b ();

  assign if_a.fire = fire;  assign if_a.player_x = px; assign if_a.player_y = py;
  assign if_a.boss_x = bx;  assign if_a.boss_y = by;   assign if_a.boss_die = bdie;
  assign if_a.x = x;        assign if_a.y = y;
  assign if_b.fire = fire;  assign if_b.player_x = px; assign if_b.player_y = py;
  assign if_b.boss_x = bx;  assign if_b.boss_y = by;   assign if_b.boss_die = bdie;
  assign if_b.x = x;        assign if_b.y = y;

  player_shot_ctrl #(.N_SHOTS(N_SHOTS), .MOVE_DIV(MOVE_DIV), .COOLDOWN(COOL_A), .SPEED(SPEED),
                     .BOSS_HW(BOSS_HW), .BOSS_HH(BOSS_HH), .SHOT_RGB(SHOT_RGB))
    dut_a (.clk_in(clk_in), .reset(reset), .sc(if_a));

  player_shot_ctrl #(.N_SHOTS(N_SHOTS), .MOVE_DIV(MOVE_DIV), .COOLDOWN(COOL_B), .SPEED(SPEED),
                     .BOSS_HW(BOSS_HW), .BOSS_HH(BOSS_HH), .SHOT_RGB(SHOT_RGB))
    dut_b (.clk_in(clk_in), .reset(reset), .sc(if_b));

  int n_checks = 0;
  int n_fail   = 0;
  int pulses_b = 0;
  int max_sa   = 0;

  // reference model, index 0 = dut_a, 1 = dut_b
  int m_cnt [2];
  bit m_act [2][N_SHOTS];
  int m_sx  [2][N_SHOTS];
  int m_sy  [2][N_SHOTS];
  int m_cd  [2];
  int m_pend[2];
  bit m_hit [2];
  int m_sa  [2];
  int cool_cfg [2];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_cd[k] = 0; m_pend[k] = 0; m_hit[k] = 1'b0; m_sa[k] = 0;
      for (int i = 0; i < N_SHOTS; i++) begin
        m_act[k][i] = 1'b0; m_sx[k][i] = 0; m_sy[k][i] = 0;
      end
    end
  endfunction

  // one clock edge of the game rules, using the inputs held during the cycle
  function automatic void model_step();
    int  sa, hits, free, avail;
    bit  tick;
    for (int k = 0; k < 2; k++) begin
      sa = 0; hits = 0; free = -1;
      for (int i = 0; i < N_SHOTS; i++) begin
        if (m_act[k][i]) sa++;
        else if (free < 0) free = i;
      end
      tick = (m_cnt[k] == MOVE_DIV - 1);
      m_cnt[k] = tick ? 0 : m_cnt[k] + 1;
      if (tick) begin
        for (int i = 0; i < N_SHOTS; i++) begin
          if (!m_act[k][i]) continue;
          if (!bdie && iabs(m_sx[k][i] - int'(bx)) <= BOSS_HW &&
                       iabs(m_sy[k][i] - int'(by)) <= BOSS_HH) begin
            m_act[k][i] = 1'b0;
            hits++;
          end else if (m_sy[k][i] < SPEED) begin
            m_act[k][i] = 1'b0;
          end else begin
            m_sy[k][i] -= SPEED;
          end
        end
        if (fire && m_cd[k] == 0 && int'(py) >= 16 && free >= 0) begin
          m_act[k][free] = 1'b1;
          m_sx[k][free]  = int'(px);
          m_sy[k][free]  = int'(py) - 16;
          m_cd[k]        = cool_cfg[k];
        end else if (m_cd[k] > 0) begin
          m_cd[k]--;
        end
      end
      avail = m_pend[k] + hits;
      if (avail > 0 && !m_hit[k]) begin
        m_hit[k] = 1'b1;
        avail--;
      end else begin
        m_hit[k] = 1'b0;
      end
      m_pend[k] = (avail > 15) ? 15 : avail;
      m_sa[k]   = sa;
    end
  endfunction

  function automatic bit model_on(int k);
    for (int i = 0; i < N_SHOTS; i++) begin
      if (m_act[k][i] &&
          int'(x) >= m_sx[k][i] - 1 && int'(x) <= m_sx[k][i] + 2 &&
          int'(y) >= m_sy[k][i] - 5 && int'(y) <= m_sy[k][i] + 6)
        return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check_outs();
    check_val("a_is_hit",  if_a.is_hit,       m_hit[0]);
    check_val("a_active",  if_a.shots_active, m_sa[0]);
    check_val("a_shot_on", if_a.shot_on,      model_on(0));
    check_val("a_rgb",     if_a.rgb_out,      model_on(0) ? SHOT_RGB : 12'h000);
    check_val("b_is_hit",  if_b.is_hit,       m_hit[1]);
    check_val("b_active",  if_b.shots_active, m_sa[1]);
    check_val("b_shot_on", if_b.shot_on,      model_on(1));
    check_val("b_rgb",     if_b.rgb_out,      model_on(1) ? SHOT_RGB : 12'h000);
  endtask

  // scan pixel: half the time near a live model shot so coverage edges get exercised
  task automatic pick_pixel();
    int k, i;
    k = int'($urandom_range(1, 0));
    i = int'($urandom_range(N_SHOTS - 1, 0));
    if ($urandom_range(1, 0) == 1 && m_act[k][i]) begin
      x = 10'(m_sx[k][i] + int'($urandom_range(5, 0)) - 2);
      y = 10'(m_sy[k][i] + int'($urandom_range(13, 0)) - 6);
    end else begin
      x = 10'($urandom_range(1023, 0));
      y = 10'($urandom_range(1023, 0));
    end
  endtask

  task automatic cycle();
    @(posedge clk_in);
    if (reset) model_reset();
    else       model_step();
    @(negedge clk_in);
    pick_pixel();
    #1;
    check_outs();
    if (if_b.is_hit === 1'b1) pulses_b++;
  endtask

  // advance until the model has just taken a movement tick (at most MOVE_DIV cycles)
  task automatic tick_cycle();
    cycle();
    for (int n = 0; n < MOVE_DIV && m_cnt[0] != 0; n++) cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check_outs();
    check_val("rst_active", if_b.shots_active, 0);
    check_val("rst_is_hit", if_b.is_hit, 0);
    check_val("rst_shot_on", if_b.shot_on, 0);
    repeat (2) cycle();
    reset = 1'b0;
  endtask

  task automatic random_inputs();
    fire = 1'($urandom_range(1, 0));
    px   = 10'($urandom_range(1023, 0));
    py   = ($urandom_range(9, 0) == 0) ? 10'($urandom_range(15, 0)) : 10'($urandom_range(1023, 0));
    bx   = ($urandom_range(1, 0) == 1) ? 10'(int'(px) + int'($urandom_range(80, 0)) - 40)
                                       : 10'($urandom_range(1023, 0));
    by   = 10'($urandom_range(600, 0));
    bdie = ($urandom_range(4, 0) == 0);
  endtask

  initial begin
    cool_cfg[0] = COOL_A;
    cool_cfg[1] = COOL_B;
    reset = 1'b0; fire = 1'b0; bdie = 1'b1;
    px = '0; py = '0; bx = '0; by = '0; x = '0; y = '0;
    model_reset();
    #2 reset = 1'b1;
    #1 check_outs();
    repeat (3) cycle();
    reset = 1'b0;

    // single shot flies up and retires off the top
    do_reset();
    bdie = 1'b1; px = 10'd192; py = 10'd400; fire = 1'b1;
    tick_cycle();
    fire = 1'b0;
    x = 10'd192; y = 10'd384; #1;
    check_val("single_pix", if_b.shot_on, 1);
    cycle();
    check_val("single_active", if_b.shots_active, 1);
    repeat (440) cycle();
    check_val("single_done", if_b.shots_active, 0);

    // one shot hits the boss exactly once
    do_reset();
    bdie = 1'b0; bx = 10'd192; by = 10'd100; px = 10'd192; py = 10'd168; fire = 1'b1;
    tick_cycle();
    fire = 1'b0;
    pulses_b = 0;
    repeat (120) cycle();
    check_val("hit_pulses", pulses_b, 1);
    check_val("hit_active", if_b.shots_active, 0);

    // pool saturates with fire held and no cooldown
    do_reset();
    bdie = 1'b1; px = 10'd300; py = 10'd60; fire = 1'b1; max_sa = 0;
    repeat (200) begin
      cycle();
      if (int'(if_b.shots_active) > max_sa) max_sa = int'(if_b.shots_active);
    end
    fire = 1'b0;
    check_val("pool_max", max_sa, N_SHOTS);

    // three shots collide on one tick: pulses on t+1, t+3, t+5
    do_reset();
    bdie = 1'b1; bx = 10'd192; by = 10'd380; px = 10'd192; py = 10'd400; fire = 1'b1;
    repeat (3) tick_cycle();
    fire = 1'b0; bdie = 1'b0; pulses_b = 0;
    tick_cycle();
    check_val("multi_t1", if_b.is_hit, 1);
    for (int n = 2; n <= 6; n++) begin
      cycle();
      check_val("multi_pulse", if_b.is_hit, n % 2);
    end
    repeat (20) cycle();
    check_val("multi_count", pulses_b, 3);

    // reset with four shots live and hits still queued
    do_reset();
    bdie = 1'b1; px = 10'd192; py = 10'd400; fire = 1'b1;
    repeat (7) tick_cycle();
    fire = 1'b0; bx = 10'd192; by = 10'd320; bdie = 1'b0;
    tick_cycle();
    do_reset();
    pulses_b = 0;
    repeat (40) cycle();
    check_val("mid_rst_no_hit", pulses_b, 0);

    // shot near the top-left corner renders at pixel (0,0) but not at x=1023
    do_reset();
    bdie = 1'b1; px = 10'd1; py = 10'd21; fire = 1'b1;
    tick_cycle();
    fire = 1'b0;
    x = 10'd0; y = 10'd0; #1;
    check_val("edge_on", if_b.shot_on, 1);
    check_val("edge_rgb", if_b.rgb_out, SHOT_RGB);
    x = 10'd1023; #1;
    check_val("edge_wrap_off", if_b.shot_on, 0);
    check_val("edge_wrap_rgb", if_b.rgb_out, 0);
    cycle();

    // randomized play with occasional resets
    do_reset();
    repeat (3000) begin
      if ($urandom_range(3, 0) == 0) random_inputs();
      if ($urandom_range(499, 0) == 0) do_reset();
      else cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
